// File: rtl/fetch_queue_if.sv
// Bundle of the PC-side, memory-side and decode-side signals of fetch_queue.
// The slave modport is the fetch stage; master is whatever drives it.
interface fetch_queue_if #(
   parameter int address_width = 32,
   parameter int data_width    = 32,
   parameter int DEPTH         = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [address_width-1:0] pc_in;
   logic                     pc_valid;
   logic                     pc_ready;
   logic                     flush;
   logic                     mem_req;
   logic [address_width-1:0] mem_addr;
   logic                     mem_rvalid;
   logic [data_width-1:0]    mem_rdata;
   logic                     instr_valid;
   logic [data_width-1:0]    instr;
   logic [address_width-1:0] instr_pc;
   logic                     instr_ready;
   // Observation only: 0=IDLE 1=WAIT 2=DROP, and FIFO occupancy
   logic [1:0]               dbg_state;
   logic [CW-1:0]            dbg_count;

   modport slave (
      input  pc_in, pc_valid, flush, mem_rvalid, mem_rdata, instr_ready,
      output pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc,
             dbg_state, dbg_count
   );

   modport master (
      output pc_in, pc_valid, flush, mem_rvalid, mem_rdata, instr_ready,
      input  pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc,
             dbg_state, dbg_count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch: one outstanding imem read, responses tagged with their PC
// and queued for decode. Optional same-cycle bypass when FETCH_BYPASS_EN is defined.
module fetch_queue #(
   parameter int address_width = 32,
   parameter int data_width    = 32,
   parameter int DEPTH         = 4
) (
   input logic          clk,
   input logic          rst,
   fetch_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

   state_t                   state_q, state_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic [address_width-1:0] pend_pc_q, pend_pc_d;
   logic [address_width-1:0] pc_mem_q [DEPTH];
   logic [address_width-1:0] pc_mem_d [DEPTH];
   logic [data_width-1:0]    ins_mem_q [DEPTH];
   logic [data_width-1:0]    ins_mem_d [DEPTH];

   logic issue, resp_ok, fifo_valid, byp_valid, pop_fifo, push;

   // Handshakes: a transfer happens in a cycle where valid && ready at the posedge;
   // ready never depends on valid, and flush suppresses every transfer that cycle.
   always_comb begin
      fifo_valid   = (count_q != '0);
      bus.pc_ready = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !bus.flush && rst;
      issue        = bus.pc_valid && bus.pc_ready;
      bus.mem_req  = issue;
      bus.mem_addr = bus.pc_in;
      resp_ok      = (state_q == WAIT) && bus.mem_rvalid && !bus.flush;
`ifdef FETCH_BYPASS_EN
      byp_valid    = resp_ok && !fifo_valid && rst;
`else
      byp_valid    = 1'b0;
`endif
      bus.instr_valid = fifo_valid || byp_valid;
      bus.instr       = '0;
      bus.instr_pc    = '0;
      if (fifo_valid) begin
         bus.instr    = ins_mem_q[rd_ptr_q];
         bus.instr_pc = pc_mem_q[rd_ptr_q];
      end
`ifdef FETCH_BYPASS_EN
      else if (byp_valid) begin
         bus.instr    = bus.mem_rdata;
         bus.instr_pc = pend_pc_q;
      end
`endif
      pop_fifo = fifo_valid && bus.instr_ready && !bus.flush;
      // A bypassed response that decode takes immediately never occupies a slot
      push     = resp_ok && !(byp_valid && bus.instr_ready);

      bus.dbg_state = state_q;
      bus.dbg_count = count_q;
   end

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      pc_mem_d  = pc_mem_q;
      ins_mem_d = ins_mem_q;

      case (state_q)
         IDLE: if (issue) state_d = WAIT;
         WAIT: begin
            if (bus.flush) state_d = bus.mem_rvalid ? IDLE : DROP;
            else if (bus.mem_rvalid) state_d = IDLE;
         end
         DROP: if (bus.mem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (issue) pend_pc_d = bus.pc_in;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]  = pend_pc_q;
            ins_mem_d[wr_ptr_q] = bus.mem_rdata;
            wr_ptr_d            = wr_ptr_q + 1'b1;
         end
         if (pop_fifo) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop_fifo) count_d = count_q + 1'b1;
         else if (!push && pop_fifo) count_d = count_q - 1'b1;
      end
   end

   // Storage is not reset: outputs are forced to zero whenever the FIFO is empty
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pend_pc_q <= pend_pc_d;
         pc_mem_q  <= pc_mem_d;
         ins_mem_q <= ins_mem_d;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table-driven reset/single-fetch vectors, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_fetch_queue;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_queue_if #(.address_width(AW), .data_width(DW), .DEPTH(DEPTH)) bus ();

   fetch_queue #(.address_width(AW), .data_width(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // exp_q holds {pc, instr} of every response decode has not yet taken
   logic [AW+DW-1:0] exp_q[$];
   bit               m_busy = 1'b0;   // a read is outstanding
   bit               m_drop = 1'b0;   // that outstanding read must be discarded
   logic [AW-1:0]    m_pend = '0;

   function automatic void model_out(input bit r, input bit pv, input bit fl, input bit rv,
                                     input logic [DW-1:0] rd,
                                     output bit e_rdy, output bit e_req, output bit e_val,
                                     output logic [AW-1:0] e_pc, output logic [DW-1:0] e_ins);
      logic [AW+DW-1:0] h;
      e_rdy = r && !m_busy && (exp_q.size() < DEPTH) && !fl;
      e_req = pv && e_rdy;
      e_val = 1'b0;
      e_pc  = '0;
      e_ins = '0;
      if (exp_q.size() > 0) begin
         h     = exp_q[0];
         e_val = 1'b1;
         e_pc  = h[AW+DW-1:DW];
         e_ins = h[DW-1:0];
      end else if (BYP && r && m_busy && !m_drop && rv && !fl) begin
         e_val = 1'b1;
         e_pc  = m_pend;
         e_ins = rd;
      end
   endfunction

   function automatic void model_step(input bit r, input bit pv, input logic [AW-1:0] pc,
                                      input bit fl, input bit rv, input logic [DW-1:0] rd,
                                      input bit ir, input bit e_rdy, input bit e_val);
      bit byp_used;
      if (!r) begin
         exp_q.delete();
         m_busy = 1'b0;
         m_drop = 1'b0;
      end else if (fl) begin
         exp_q.delete();
         if (m_busy && !m_drop) begin
            if (rv) m_busy = 1'b0;
            else    m_drop = 1'b1;
         end else if (m_busy && m_drop && rv) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
         end
      end else begin
         byp_used = 1'b0;
         if (e_val && ir) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else byp_used = 1'b1;
         end
         if (m_busy && rv) begin
            if (!m_drop && !byp_used) exp_q.push_back({m_pend, rd});
            m_busy = 1'b0;
            m_drop = 1'b0;
         end
         if (pv && e_rdy) begin
            m_busy = 1'b1;
            m_pend = pc;
         end
      end
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   bit            a_rdy, a_req, a_val;
   logic [AW-1:0] a_addr, a_pc;
   logic [DW-1:0] a_ins;
   logic [1:0]    a_state;
   logic [2:0]    a_cnt;

   // ---------------- driver: one clock cycle ----------------
   task automatic drive(input bit r, input bit pv, input logic [AW-1:0] pc, input bit fl,
                        input bit rv, input logic [DW-1:0] rd, input bit ir);
      bit            e_rdy, e_req, e_val;
      logic [AW-1:0] e_pc;
      logic [DW-1:0] e_ins;
      @(negedge clk);
      rst             = r;
      bus.pc_valid    = pv;
      bus.pc_in       = pc;
      bus.flush       = fl;
      bus.mem_rvalid  = rv;
      bus.mem_rdata   = rd;
      bus.instr_ready = ir;
      #1;
      model_out(r, pv, fl, rv, rd, e_rdy, e_req, e_val, e_pc, e_ins);
      a_rdy   = bus.pc_ready;
      a_req   = bus.mem_req;
      a_addr  = bus.mem_addr;
      a_val   = bus.instr_valid;
      a_pc    = bus.instr_pc;
      a_ins   = bus.instr;
      a_state = bus.dbg_state;
      a_cnt   = bus.dbg_count;
      check("pc_ready", a_rdy, e_rdy);
      check("mem_req", a_req, e_req);
      if (e_req) check("mem_addr", a_addr, pc);
      check("instr_valid", a_val, e_val);
      check("instr_pc", a_pc, e_pc);
      check("instr", a_ins, e_ins);
      check("state", a_state, m_busy ? (m_drop ? 2 : 1) : 0);
      check("count", a_cnt, exp_q.size());
      @(posedge clk);
      model_step(r, pv, pc, fl, rv, rd, ir, e_rdy, e_val);
   endtask

   task automatic idle(input bit ir);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, ir);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit            r, pv;
      logic [AW-1:0] pc;
      bit            fl, rv;
      logic [DW-1:0] rd;
      bit            ir;
      bit            e_rdy, e_req, e_val;
      logic [AW-1:0] e_pc;
      logic [DW-1:0] e_ins;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.pc_valid    = 1'b0;
      bus.pc_in       = '0;
      bus.flush       = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
      bus.instr_ready = 1'b0;

      // reset held 3 cycles with pc_valid, then a single fetch of 0x10
      tbl[0] = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      tbl[2] = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      tbl[3] = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 1'b0, BYP,
                 BYP ? 32'h10 : 32'h0, BYP ? 32'h0050_0093 : 32'h0};
      tbl[6] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, !BYP,
                 BYP ? 32'h0 : 32'h10, BYP ? 32'h0 : 32'h0050_0093};
      tbl[7] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].r, tbl[i].pv, tbl[i].pc, tbl[i].fl, tbl[i].rv, tbl[i].rd, tbl[i].ir);
         check($sformatf("tbl%0d_pc_ready", i), a_rdy, tbl[i].e_rdy);
         check($sformatf("tbl%0d_mem_req", i), a_req, tbl[i].e_req);
         if (tbl[i].e_req) check($sformatf("tbl%0d_mem_addr", i), a_addr, tbl[i].pc);
         check($sformatf("tbl%0d_instr_valid", i), a_val, tbl[i].e_val);
         check($sformatf("tbl%0d_instr_pc", i), a_pc, tbl[i].e_pc);
         check($sformatf("tbl%0d_instr", i), a_ins, tbl[i].e_ins);
      end

      // full: four fetches with decode stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, AW'(i * 4), 1'b0, 1'b0, '0, 1'b0);
         drive(1'b1, 1'b0, '0, 1'b0, 1'b1, DW'(32'hA000_0000 + i), 1'b0);
      end
      drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, '0, 1'b0);
      check("full_pc_ready", a_rdy, 1'b0);
      check("full_count", a_cnt, 4);
      check("full_head_pc", a_pc, 32'h0);
      idle(1'b0);
      check("full_head_stable", a_pc, 32'h0);
      idle(1'b1);
      check("full_pop_pc", a_pc, 32'h0);
      idle(1'b0);
      check("after_pop_pc_ready", a_rdy, 1'b1);
      for (int k = 1; k < 4; k++) begin
         idle(1'b1);
         check("order_pc", a_pc, AW'(k * 4));
         check("order_instr", a_ins, DW'(32'hA000_0000 + k));
      end

      // flush while the read of 0x20 is in flight
      drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, '0, 1'b1);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      check("drop_state", a_state, 2'd1);
      idle(1'b1);
      check("drop_pc_ready", a_rdy, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      check("drop_no_valid", a_val, 1'b0);
      drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, 1'b0);
      check("redirect_issue", a_req, 1'b1);
      check("redirect_addr", a_addr, 32'h100);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
      idle(1'b1);
      check("redirect_valid", a_val, 1'b1);
      check("redirect_pc", a_pc, 32'h100);
      check("redirect_instr", a_ins, 32'h1234_5678);

      // flush and rvalid together with two entries queued
      drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
      drive(1'b1, 1'b1, 32'h204, 1'b0, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h0000_0204, 1'b0);
      drive(1'b1, 1'b1, 32'h208, 1'b0, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h0000_0208, 1'b1);
      check("flush_rv_pre_count", a_cnt, 2);
      idle(1'b0);
      check("flush_rv_count", a_cnt, 0);
      check("flush_rv_valid", a_val, 1'b0);
      check("flush_rv_state", a_state, 2'd0);

      // reset while a read is outstanding
      drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      check("rst_mid_pc_ready", a_rdy, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hBAD0_0040, 1'b1);
      check("rst_mid_valid", a_val, 1'b0);
      check("rst_mid_state", a_state, 2'd0);
      idle(1'b1);
      check("rst_mid_valid_after", a_val, 1'b0);
      check("rst_mid_count", a_cnt, 0);

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 99) != 0,
               $urandom_range(0, 9) < 7,
               AW'($urandom() & 32'hFFFF_FFFC),
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 4,
               DW'($urandom()),
               $urandom_range(0, 9) < 6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
